conv_relu_maxpool_stream: RTL and testbench



---
 rtl/conv_relu_maxpool_stream.sv | 124 ++++++++++++
 tb/tb_conv_relu_maxpool_stream.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_relu_maxpool_stream.sv
// Captures one parallel conv output frame, then streams ReLU + max-pooled values
// one per cycle over a valid/ready interface.
module conv_relu_maxpool_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 128,
    parameter int K          = 2,
    localparam int M         = N / K,
    localparam int IW        = $clog2(M)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:N*DATA_WIDTH-1]   in_vector,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [IW-1:0]             out_index,
    output logic                      out_last
);

    localparam int NW = $clog2(N);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                        state_reg;
    logic                          out_valid_reg;
    logic [DATA_WIDTH-1:0]         out_data_reg;
    logic [IW-1:0]                 out_index_reg;
    logic                          out_last_reg;

    logic signed [DATA_WIDTH-1:0]  in_elems  [N];
    logic signed [DATA_WIDTH-1:0]  frame_reg [N];

    logic [IW-1:0]                 next_group;
    logic [NW-1:0]                 group_base;
    logic signed [DATA_WIDTH-1:0]  pool_next;
    logic signed [DATA_WIDTH-1:0]  cand;

    // Element 0 sits in the leftmost slice of the ascending input vector.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign in_elems[gi] = in_vector[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // In IDLE the next group is group 0 taken straight from the incoming frame,
    // so the first pooled value is ready at the accepting edge.
    always_comb begin
        next_group = out_index_reg + IW'(1);
        group_base = NW'(next_group) * NW'(K);
        pool_next  = '0;
        cand       = '0;
        for (int k = 0; k < K; k++) begin
            if (state_reg == IDLE) begin
                cand = in_elems[NW'(k)];
            end else begin
                cand = frame_reg[group_base + NW'(k)];
            end
            if (cand > pool_next) begin
                pool_next = cand;
            end
        end
    end

    // The frame buffer needs no reset: it is only read after a capture.
    always_ff @(posedge clk) begin
        if (state_reg == IDLE && in_valid) begin
            for (int i = 0; i < N; i++) begin
                frame_reg[i] <= in_elems[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_index_reg <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        out_data_reg  <= pool_next;
                        out_valid_reg <= 1'b1;
                        out_index_reg <= '0;
                        out_last_reg  <= (M == 1);
                        state_reg     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_index_reg == IW'(M - 1)) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            state_reg     <= IDLE;
                        end else begin
                            out_data_reg  <= pool_next;
                            out_index_reg <= next_group;
                            out_last_reg  <= (next_group == IW'(M - 1));
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_index = out_index_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_conv_relu_maxpool_stream.sv
// Self-checking bench for conv_relu_maxpool_stream: table vectors for pool corner
// values plus randomized frames checked against a plain max(0, window) model.
module tb_conv_relu_maxpool_stream;

    localparam int DW = 16;
    localparam int N  = 128;
    localparam int K  = 2;
    localparam int M  = N / K;
    localparam int IW = $clog2(M);

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [0:N*DW-1]   in_vector;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_index;
    logic              out_last;

    always #5 clk = ~clk;

    conv_relu_maxpool_stream #(
        .DATA_WIDTH (DW),
        .N          (N),
        .K          (K)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vector  (in_vector),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t            tab [8];
    int              vectors     = 0;
    int              miscompares = 0;
    int              xa [N];
    int              exp_buf [2][M];
    logic [0:N*DW-1] vec_buf [2];
    int              sel = 0;
    int              frame_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic random_frame();
        logic signed [15:0] r;
        for (int i = 0; i < N; i++) begin
            r = 16'($urandom);
            xa[i] = int'(r);
        end
    endtask

    // Reference: each pooled output is max(0, window elements); pack frame as ports expect.
    task automatic build(input int which);
        int m;
        for (int g = 0; g < M; g++) begin
            m = 0;
            for (int k = 0; k < K; k++) begin
                if (xa[g*K + k] > m) m = xa[g*K + k];
            end
            exp_buf[which][g] = m;
        end
        for (int i = 0; i < N; i++) begin
            vec_buf[which][i*DW +: DW] = xa[i][DW-1:0];
        end
    endtask

    task automatic send(input int which);
        int n = 0;
        in_vector = vec_buf[which];
        in_valid  = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            miscompares++;
            $display("FAIL send_timeout: in_ready never rose");
        end
        tick();
        in_valid = 1'b0;
        check("latency_valid", out_valid, 1);
        check("first_index", out_index, 0);
    endtask

    task automatic collect(input int ready_pct, input int stop_g, output int cyc);
        int g = 0;
        cyc = 0;
        while (g < stop_g && cyc < 2000) begin
            check("out_valid", out_valid, 1);
            check("in_ready_low", in_ready, 0);
            check("out_index", out_index, g);
            check("out_data", out_data, exp_buf[sel][g]);
            check("out_last", out_last, (g == M - 1));
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid && out_ready) g++;
            tick();
            cyc++;
        end
        if (cyc >= 2000) begin
            miscompares++;
            $display("FAIL collect_timeout: beats=%0d required=%0d", g, stop_g);
        end
        if (stop_g == M) begin
            check("done_valid", out_valid, 0);
            check("done_last", out_last, 0);
            check("in_ready_back", in_ready, 1);
        end
        frame_no++;
        $display("frame %0d: %0d beats in %0d cycles", frame_no, g, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        tab[0] = '{16'h8000, 16'hFFFF, 16'h0000};
        tab[1] = '{16'h7FFF, 16'h8000, 16'h7FFF};
        tab[2] = '{16'h0005, 16'h0005, 16'h0005};
        tab[3] = '{16'hFFFD, 16'h0007, 16'h0007};
        tab[4] = '{16'h0007, 16'hFFFD, 16'h0007};
        tab[5] = '{16'h0000, 16'h0000, 16'h0000};
        tab[6] = '{16'hFFFF, 16'hFFFF, 16'h0000};
        tab[7] = '{16'h0001, 16'h0002, 16'h0002};

        // Reset with a frame presented: it must not be captured.
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_vector = '1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        check("idle_no_capture", out_valid, 0);

        // Table: each pair lands in group 0 of its own frame.
        for (int j = 0; j < 8; j++) begin
            random_frame();
            xa[0] = int'($signed(tab[j].a));
            xa[1] = int'($signed(tab[j].b));
            sel = 0;
            build(0);
            send(0);
            check($sformatf("table_%0d", j), out_data, tab[j].exp);
            collect(100, M, cyc);
        end

        // Ramp frame with continuous ready: M beats on consecutive cycles.
        for (int i = 0; i < N; i++) xa[i] = i - 64;
        sel = 0;
        build(0);
        send(0);
        collect(100, M, cyc);
        check("ramp_throughput", cyc, M);

        // Backpressure with an intruding frame offered during the stream.
        random_frame();
        build(1);
        random_frame();
        build(0);
        sel = 0;
        send(0);
        in_vector = vec_buf[1];
        in_valid  = 1'b1;
        collect(50, M, cyc);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready_no_effect", out_valid, 0);
        end

        // Back-to-back: second frame held on in_valid throughout the first.
        random_frame();
        build(0);
        random_frame();
        build(1);
        sel = 0;
        send(0);
        in_vector = vec_buf[1];
        in_valid  = 1'b1;
        collect(100, M, cyc);
        sel = 1;
        tick();
        in_valid = 1'b0;
        check("b2b_accept_valid", out_valid, 1);
        check("b2b_accept_index", out_index, 0);
        collect(100, M, cyc);

        // Reset at beat 20, then a fresh frame.
        random_frame();
        sel = 0;
        build(0);
        send(0);
        collect(100, 20, cyc);
        check("pre_reset_index", out_index, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_index", out_index, 0);
        check("midrst_in_ready", in_ready, 1);
        random_frame();
        build(0);
        send(0);
        collect(60, M, cyc);

        // A few more random frames under random backpressure.
        for (int f = 0; f < 3; f++) begin
            random_frame();
            build(0);
            send(0);
            collect(30 + 25 * f, M, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
